nibble_serial_adder: RTL and testbench
======================================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits; legal values are multiples of 4 in the range 4..64.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1: operand set present on a, b, cin.
REQ-005 SHALL have port in_ready, output, 1: block can accept an operand set.
REQ-006 SHALL have port a, input, WIDTH: addend A.
REQ-007 SHALL have port b, input, WIDTH: addend B.
REQ-008 SHALL have port cin, input, 1: carry-in to bit 0.
REQ-009 SHALL have port out_valid, output, 1: result present on s, cout, ovf.
REQ-010 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-011 SHALL have port s, output, WIDTH: sum, equal to (a+b+cin) mod 2^WIDTH.
REQ-012 SHALL have port cout, output, 1: carry out of bit WIDTH-1.
REQ-013 SHALL have port ovf, output, 1: two's-complement overflow.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-016 SHALL perform an accept when in_valid&&in_ready at a clock edge. On accept it SHALL:
- register a, b and cin;
- clear the nibble index to 0;
- clear s to 0;
- enter RUN.
REQ-017 SHALL, in each RUN cycle, compute the nibble at index i (bits 4i+3..4i) of the registered operands with a 4-bit carry-lookahead slice:
- g=a&b, p=a^b;
- c[k]=g[k]|(p[k]&c[k-1]), with c[-1] taken from the carry register;
- write the 4 sum bits into s[4i+3:4i];
- load c[3] into the carry register;
- increment i.
REQ-018 SHALL leave RUN for DONE on the edge that processes nibble WIDTH/4-1. out_valid therefore rises exactly WIDTH/4+1 edges after the accept edge (5 edges for WIDTH=16).
REQ-019 SHALL set cout to the final carry, and ovf to (carry into bit WIDTH-1) XOR cout, both on the edge that enters DONE.
REQ-020 SHALL hold s, cout and ovf stable throughout DONE until out_valid&&out_ready, then return to IDLE on that edge.
REQ-021 SHALL keep s, cout and ovf at their last values in IDLE. They are meaningful only while out_valid=1.
REQ-022 SHALL ignore in_valid in RUN and DONE. No operand is lost, because in_ready=0 there.
REQ-023 SHALL NOT accept new operands on the same edge that releases DONE. The earliest next accept is one cycle after the result transfer.
REQ-024 SHALL ignore changes on a, b and cin after the accept edge.

Reset
REQ-025 SHALL, while rst=1, force the following regardless of clk, including mid-RUN or in DONE:
- state=IDLE;
- nibble index=0;
- carry register=0;
- s=0, cout=0, ovf=0;
- out_valid=0;
- in_ready=1.
REQ-026 SHALL discard any in-flight operation on reset. The first accept is possible on the first clk edge after rst falls.

Verification
All scenarios use WIDTH=16.
REQ-027 Basic add: a=0x1234, b=0x4321, cin=0 -> s=0x5555, cout=0, ovf=0; out_valid rises 5 edges after accept.
REQ-028 Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1, ovf=0.
REQ-029 Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> s=0x8000, cout=0, ovf=1.
REQ-030 Maximum operands with carry-in: a=0xFFFF, b=0xFFFF, cin=1 -> s=0xFFFF, cout=1, ovf=0.
REQ-031 Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands. Required: s, cout and ovf stay stable; in_ready=0; the new operands are not accepted. Then raise out_ready -> transfer; IDLE on the next edge; next accept one cycle later.
REQ-032 Reset mid-operation: assert rst in the 2nd RUN cycle. Required: out_valid=0, s=0 and in_ready=1 immediately. After release, a=0x0008, b=0x0008, cin=0 -> s=0x0010, cout=0, ovf=0.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle adder that processes one 4-bit nibble per clock
// with a 4-bit carry-lookahead slice, from the least significant nibble upwards.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand set present on a, b, cin
//   in_ready   high only in IDLE; an accept is in_valid && in_ready at a clock edge
//   a, b       WIDTH-bit addends, registered on accept
//   cin        carry-in to bit 0, registered on accept
//   out_valid  high only in DONE; s, cout and ovf are meaningful while it is high
//   out_ready  consumer takes the result; DONE -> IDLE on out_valid && out_ready
//   s          sum, (a + b + cin) mod 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   ovf        two's-complement overflow
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q;

  logic [IDX_W+1:0] base;
  logic [3:0]       an, bn, g, p, c, sum;
  logic             last_nib;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  // Nibble slice: lookahead carries within the nibble, chained through carry_q.
  always_comb begin
    base     = {idx_q, 2'b00};
    an       = a_q[base +: 4];
    bn       = b_q[base +: 4];
    g        = an & bn;
    p        = an ^ bn;
    c[0]     = g[0] | (p[0] & carry_q);
    c[1]     = g[1] | (p[1] & c[0]);
    c[2]     = g[2] | (p[2] & c[1]);
    c[3]     = g[3] | (p[3] & c[2]);
    sum      = p ^ {c[2:0], carry_q};
    last_nib = (idx_q == LAST_IDX);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last_nib) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            s       <= '0;
          end
        end
        RUN: begin
          s[base +: 4] <= sum;
          carry_q      <= c[3];
          idx_q        <= idx_q + 1'b1;
          if (last_nib) begin
            cout <= c[3];
            // c[2] of the top nibble is the carry into bit WIDTH-1.
            ovf  <= c[2] ^ c[3];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed and randomized checks of nibble_serial_adder (WIDTH=16)
// against a plain-arithmetic reference model.
module tb_nibble_serial_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, cout, ovf;
  logic [W-1:0] s;

  int n_checks = 0;
  int n_fail   = 0;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: returns {ovf, cout, s}.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    logic [W:0]   t;
    logic [W-1:0] r;
    logic         v;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    r = t[W-1:0];
    v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    return {v, t[W], r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, presents one operand set for the accept edge, then scrambles inputs.
  task automatic start_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (ok) begin
      a = xa;
      b = xb;
      cin = xc;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
    end
  endtask

  // Counts edges with the accept edge as edge 1; stops once out_valid is seen.
  task automatic wait_done(output int lat, output bit ok);
    lat = 1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1/0", in_ready,
               out_valid);
    end
    n_checks++;
    if ({ovf, cout, s} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: {ovf,cout,s}=%h, required 0", {ovf, cout, s});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[4] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'hFFFF};
    logic [W-1:0] tb[4] = '{16'h4321, 16'h0001, 16'h0001, 16'hFFFF};
    logic         tc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [W+1:0] te[4] = '{{2'b00, 16'h5555}, {2'b01, 16'h0000}, {2'b10, 16'h8000},
                            {2'b01, 16'hFFFF}};
    int lat;
    bit ok;
    for (int k = 0; k < 4; k++) begin
      start_op(ta[k], tb[k], tc[k], ok);
      if (ok) wait_done(lat, ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL directed_%0d_timeout: no handshake within bound", k);
        continue;
      end
      n_checks++;
      if (lat != 5) begin
        n_fail++;
        $display("FAIL directed_%0d_latency: got %0d edges, required 5", k, lat);
      end
      n_checks++;
      if ({ovf, cout, s} !== te[k]) begin
        n_fail++;
        $display("FAIL directed_%0d_result: {ovf,cout,s}=%h, required %h", k, {ovf, cout, s},
                 te[k]);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL directed_%0d_release: out_valid=%b in_ready=%b, required 0/1", k,
                 out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W+1:0] exp1, exp2;
    int lat;
    bit ok;
    exp1 = model(16'h1234, 16'hABCD, 1'b1);
    exp2 = model(16'h0F0F, 16'h0101, 1'b0);
    start_op(16'h1234, 16'hABCD, 1'b1, ok);
    if (ok) wait_done(lat, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bp_timeout: no handshake within bound");
      return;
    end
    in_valid = 1'b1;
    a = 16'h0F0F;
    b = 16'h0101;
    cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {ovf, cout, s} !== exp1) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b result=%h, required 1/0/%h", i,
                 out_valid, in_ready, {ovf, cout, s}, exp1);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_transfer: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    step();
    in_valid = 1'b0;
    a = 16'hDEAD;
    b = 16'hBEEF;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_next_accept: in_ready=%b, required 0", in_ready);
    end
    wait_done(lat, ok);
    n_checks++;
    if (!ok || lat != 5 || {ovf, cout, s} !== exp2) begin
      n_fail++;
      $display("FAIL bp_second_result: ok=%b lat=%0d result=%h, required 1/5/%h", ok, lat,
               {ovf, cout, s}, exp2);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    bit ok;
    start_op(16'hFFFF, 16'h0001, 1'b0, ok);
    step();
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || {ovf, cout, s} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: out_valid=%b in_ready=%b result=%h, required 0/1/0", out_valid,
               in_ready, {ovf, cout, s});
    end
    @(negedge clk);
    rst = 1'b0;
    start_op(16'h0008, 16'h0008, 1'b0, ok);
    if (ok) wait_done(lat, ok);
    n_checks++;
    if (!ok || lat != 5 || {ovf, cout, s} !== {2'b00, 16'h0010}) begin
      n_fail++;
      $display("FAIL rst_after: ok=%b lat=%0d result=%h, required 1/5/%h", ok, lat,
               {ovf, cout, s}, {2'b00, 16'h0010});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] xa, xb;
    logic         xc;
    logic [W+1:0] exp;
    int lat, dly;
    bit ok;
    for (int k = 0; k < 40; k++) begin
      xa = W'($urandom);
      xb = W'($urandom);
      xc = 1'($urandom);
      if (k % 4 == 0) xb = ~xa;
      exp = model(xa, xb, xc);
      start_op(xa, xb, xc, ok);
      if (ok) wait_done(lat, ok);
      n_checks++;
      if (!ok || lat != 5) begin
        n_fail++;
        $display("FAIL rand_%0d_latency: ok=%b lat=%0d, required 1/5", k, ok, lat);
        continue;
      end
      dly = int'($urandom_range(0, 2));
      for (int i = 0; i < dly; i++) step();
      n_checks++;
      if ({ovf, cout, s} !== exp) begin
        n_fail++;
        $display("FAIL rand_%0d_result: a=%h b=%h cin=%b got %h, required %h", k, xa, xb, xc,
                 {ovf, cout, s}, exp);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
